mem_port_arbiter: RTL and testbench

- Shares the single external memory port between instruction fetch (IF) and the memory-access stage (LD/LDR/ST).
- Sequences each access with a req/ack handshake and generates the pipeline stall signals.
- Enforces a bounded wait and reports a bus error so the exception path can raise it.
- Sits between the fetch/mem_access stages and the external memory.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/bus_watchdog.sv | 38 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int TIMEOUT_CYCLES_DEF = 64;
    localparam int STARVE_MAX_DEF     = 4;

endpackage

// File: rtl/bus_watchdog.sv
// Bus watchdog: counts busy cycles without ack, flags expiry.
// Latency: expire is combinational on the count reaching TIMEOUT_CYCLES-1.
// Backpressure: none; clr has priority over en.
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en & (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between fetch and data access.
// Latency: grant in IDLE, ext_req next cycle, completion on ext_ack; >=2 cycles/access.
// Backpressure: requesters hold under stall_if/stall_mem until their valid pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int STARVE_MAX     = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_err,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        dm_err,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        ext_req,
    output logic        ext_we,
    output logic [31:0] ext_addr,
    output logic [31:0] ext_wdata,
    input  logic        ext_ack,
    input  logic [31:0] ext_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_t    state_q, state_d;
    logic          ext_req_q, ext_req_d;
    logic          ext_we_q, ext_we_d;
    logic [31:0]   ext_addr_q, ext_addr_d;
    logic [31:0]   ext_wdata_q, ext_wdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          wd_clr, wd_en, wd_expire;
    logic          dm_op;
    owner_t        owner;

    assign dm_op = dm_rd | dm_wr;
    assign owner = (state_q == DM_BUSY) ? OWN_DM : OWN_IF;

    bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        starve_d    = starve_q;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;
        if_valid    = 1'b0;
        if_err      = 1'b0;
        if_rdata    = '0;
        dm_valid    = 1'b0;
        dm_err      = 1'b0;
        dm_rdata    = '0;
        case (state_q)
            IDLE: begin
                if (dm_op && (starve_q < STARVE_LIM)) begin
                    state_d     = DM_BUSY;
                    ext_req_d   = 1'b1;
                    ext_we_d    = dm_wr;
                    ext_addr_d  = dm_addr;
                    ext_wdata_d = dm_wdata;
                    wd_clr      = 1'b1;
                    // Only grants that actually make fetch wait count toward starvation.
                    starve_d    = if_req ? (starve_q + SW'(1)) : '0;
                end else if (if_req) begin
                    state_d     = IF_BUSY;
                    ext_req_d   = 1'b1;
                    ext_we_d    = 1'b0;
                    ext_addr_d  = if_addr;
                    ext_wdata_d = '0;
                    wd_clr      = 1'b1;
                    starve_d    = '0;
                end
            end
            DM_BUSY, IF_BUSY: begin
                wd_en = 1'b1;
                // An ack on the expiry cycle still counts as a good completion.
                if (ext_ack || wd_expire) begin
                    state_d   = IDLE;
                    ext_req_d = 1'b0;
                    ext_we_d  = 1'b0;
                    if (owner == OWN_DM) begin
                        dm_valid = 1'b1;
                        dm_err   = ~ext_ack;
                        dm_rdata = (ext_ack && !ext_we_q) ? ext_rdata : '0;
                    end else begin
                        if_valid = 1'b1;
                        if_err   = ~ext_ack;
                        if_rdata = ext_ack ? ext_rdata : '0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                ext_req_d = 1'b0;
                ext_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            starve_q    <= starve_d;
        end
    end

    assign ext_req   = ext_req_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;

    assign stall_mem = dm_op & ~dm_valid;
    assign stall_if  = (if_req & ~if_valid) | stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario tasks plus a randomized run against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_rd, dm_wr, ext_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, ext_rdata;
    logic [31:0] if_rdata, dm_rdata, ext_addr, ext_wdata;
    logic        if_valid, if_err, dm_valid, dm_err;
    logic        stall_if, stall_mem, ext_req, ext_we;

    int vectors = 0;
    int errors  = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_err(if_err),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_err(dm_err),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = 0; dm_rd = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0;
        ext_ack = 0; ext_rdata = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #3;
        vectors++; if (ext_req !== 1'b0 || ext_we !== 1'b0) begin errors++; $display("FAIL reset_req_we got %b%b exp 00", ext_req, ext_we); end
        vectors++; if (ext_addr !== 32'h0 || ext_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata got %h/%h exp 0/0", ext_addr, ext_wdata); end
        vectors++; if ({if_valid, if_err, dm_valid, dm_err, stall_if, stall_mem} !== 6'b0) begin errors++; $display("FAIL reset_outputs got %b exp 000000", {if_valid, if_err, dm_valid, dm_err, stall_if, stall_mem}); end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_fetch();
        cyc(); if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        vectors++; if (ext_req !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL fetch_c0 req=%b stall_if=%b exp 0/1", ext_req, stall_if); end
        for (int c = 1; c <= 3; c++) begin
            cyc(); ext_ack = (c == 3); ext_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0;
            @(negedge clk);
            vectors++; if (ext_req !== 1'b1 || ext_addr !== 32'h100 || ext_we !== 1'b0) begin errors++; $display("FAIL fetch_ext c=%0d req=%b addr=%h we=%b exp 1/100/0", c, ext_req, ext_addr, ext_we); end
            vectors++; if (if_valid !== (c == 3)) begin errors++; $display("FAIL fetch_valid c=%0d got %b exp %b", c, if_valid, (c == 3)); end
        end
        vectors++; if (if_rdata !== 32'hDEADBEEF || if_err !== 1'b0) begin errors++; $display("FAIL fetch_rdata got %h err=%b exp deadbeef/0", if_rdata, if_err); end
        vectors++; if (stall_if !== 1'b0) begin errors++; $display("FAIL fetch_stall_c3 got %b exp 0", stall_if); end
        cyc(); if_req = 0; ext_ack = 0;
        @(negedge clk);
        vectors++; if (ext_req !== 1'b0 || if_valid !== 1'b0 || stall_if !== 1'b0) begin errors++; $display("FAIL fetch_after req=%b valid=%b stall=%b exp 000", ext_req, if_valid, stall_if); end
    endtask

    task automatic test_ld_and_fetch();
        cyc(); dm_rd = 1; dm_addr = 32'h40; if_req = 1; if_addr = 32'h104;
        @(negedge clk);
        vectors++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin errors++; $display("FAIL ldf_c0_stall got %b%b exp 11", stall_if, stall_mem); end
        cyc(); ext_ack = 1; ext_rdata = 32'h5555AAAA;
        @(negedge clk);
        vectors++; if (ext_addr !== 32'h40 || ext_we !== 1'b0 || ext_req !== 1'b1) begin errors++; $display("FAIL ldf_dgrant addr=%h we=%b req=%b exp 40/0/1", ext_addr, ext_we, ext_req); end
        vectors++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h5555AAAA || if_valid !== 1'b0) begin errors++; $display("FAIL ldf_dvalid v=%b d=%h iv=%b exp 1/5555aaaa/0", dm_valid, dm_rdata, if_valid); end
        vectors++; if (stall_if !== 1'b1) begin errors++; $display("FAIL ldf_stall_if got %b exp 1", stall_if); end
        cyc(); dm_rd = 0; ext_ack = 0;
        @(negedge clk);
        vectors++; if (ext_req !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL ldf_idle req=%b stall=%b exp 0/1", ext_req, stall_if); end
        cyc(); ext_ack = 1; ext_rdata = 32'h0BADF00D;
        @(negedge clk);
        vectors++; if (ext_req !== 1'b1 || ext_addr !== 32'h104 || if_valid !== 1'b1 || if_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL ldf_fgrant req=%b addr=%h v=%b d=%h", ext_req, ext_addr, if_valid, if_rdata); end
        cyc(); if_req = 0; ext_ack = 0;
    endtask

    task automatic test_store();
        cyc(); dm_wr = 1; dm_addr = 32'h80; dm_wdata = 32'h12345678;
        cyc(); ext_ack = 1; ext_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        vectors++; if (ext_we !== 1'b1 || ext_wdata !== 32'h12345678 || ext_addr !== 32'h80) begin errors++; $display("FAIL st_ext we=%b wd=%h a=%h exp 1/12345678/80", ext_we, ext_wdata, ext_addr); end
        vectors++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h0 || dm_err !== 1'b0) begin errors++; $display("FAIL st_done v=%b d=%h e=%b exp 1/0/0", dm_valid, dm_rdata, dm_err); end
        cyc(); dm_wr = 0; ext_ack = 0;
        @(negedge clk);
        vectors++; if (ext_we !== 1'b0 || ext_req !== 1'b0) begin errors++; $display("FAIL st_after we=%b req=%b exp 0/0", ext_we, ext_req); end
    endtask

    task automatic test_starvation();
        int g = 0;
        logic [31:0] exp_a;
        dm_rd = 1; dm_addr = 32'h200; if_req = 1; if_addr = 32'h300;
        for (int c = 0; c < 40 && g < 10; c++) begin
            cyc(); ext_ack = ext_req; ext_rdata = 32'h0;
            @(negedge clk);
            if (ext_req) begin
                exp_a = ((g % 5) == 4) ? 32'h300 : 32'h200;
                vectors++; if (ext_addr !== exp_a) begin errors++; $display("FAIL starve_grant g=%0d got %h exp %h", g, ext_addr, exp_a); end
                g++;
            end
        end
        vectors++; if (g !== 10) begin errors++; $display("FAIL starve_count got %0d exp 10", g); end
        cyc(); clear_inputs();
    endtask

    task automatic test_timeout();
        cyc(); dm_rd = 1; dm_addr = 32'h44;
        for (int c = 1; c <= 64; c++) begin
            cyc(); ext_ack = 0; ext_rdata = 32'hCAFE0000;
            @(negedge clk);
            vectors++; if (ext_req !== 1'b1 || dm_valid !== (c == 64) || dm_err !== (c == 64)) begin errors++; $display("FAIL tmo c=%0d req=%b v=%b e=%b", c, ext_req, dm_valid, dm_err); end
        end
        vectors++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata got %h exp 0", dm_rdata); end
        cyc(); dm_rd = 0; ext_ack = 1; ext_rdata = 32'h99;
        @(negedge clk);
        vectors++; if (ext_req !== 1'b0 || dm_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL tmo_late req=%b dv=%b iv=%b exp 000", ext_req, dm_valid, if_valid); end
        cyc(); ext_ack = 0;
    endtask

    task automatic test_reset_mid_busy();
        cyc(); dm_wr = 1; dm_addr = 32'h88; dm_wdata = 32'hA5A5A5A5;
        cyc();
        @(negedge clk);
        vectors++; if (ext_req !== 1'b1 || ext_we !== 1'b1) begin errors++; $display("FAIL rstmid_busy req=%b we=%b exp 1/1", ext_req, ext_we); end
        #1 rst_n = 0;
        #1;
        vectors++; if (ext_req !== 1'b0 || ext_we !== 1'b0 || ext_addr !== 32'h0) begin errors++; $display("FAIL rstmid_async req=%b we=%b a=%h exp 0/0/0", ext_req, ext_we, ext_addr); end
        dm_wr = 0;
        @(negedge clk); rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            cyc(); ext_ack = (c == 1);
            @(negedge clk);
            vectors++; if (ext_req !== 1'b0 || dm_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after c=%0d req=%b dv=%b iv=%b", c, ext_req, dm_valid, if_valid); end
        end
        ext_ack = 0;
    endtask

    // Model: one owner at a time; data wins unless fetch has waited through STARVE_MAX data grants.
    task automatic test_random();
        logic [31:0] mem [16];
        int owner = 0;
        int starve = 0, lat = 0, waitc = 0;
        bit d_act = 0, d_we = 0, i_act = 0, ack, d_done, i_done;
        logic [31:0] d_a = 0, d_wd = 0, i_a = 0, exp_a = 0, exp_d;
        bit exp_we = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        clear_inputs();
        rst_n = 0; #2; rst_n = 1;
        for (int c = 0; c < 400; c++) begin
            cyc();
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1; d_we = $urandom_range(0, 1); d_a = {26'h0, 4'($urandom_range(0, 15)), 2'b00}; d_wd = $urandom;
            end
            if (!i_act && $urandom_range(0, 1) == 0) begin
                i_act = 1; i_a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            end
            dm_rd = d_act & !d_we; dm_wr = d_act & d_we; dm_addr = d_a; dm_wdata = d_wd;
            if_req = i_act; if_addr = i_a;
            ack = (owner != 0) && (waitc == lat);
            ext_ack = ack;
            ext_rdata = (ack && !exp_we) ? mem[exp_a[5:2]] : $urandom;
            @(negedge clk);
            d_done = ack && owner == 2;
            i_done = ack && owner == 1;
            vectors++; if (stall_mem !== (d_act && !d_done) || stall_if !== ((i_act && !i_done) || (d_act && !d_done))) begin errors++; $display("FAIL rnd_stall c=%0d got %b%b", c, stall_if, stall_mem); end
            vectors++; if (dm_valid !== d_done || if_valid !== i_done || dm_err !== 1'b0 || if_err !== 1'b0) begin errors++; $display("FAIL rnd_valid c=%0d dv=%b iv=%b exp %b%b", c, dm_valid, if_valid, d_done, i_done); end
            if (owner != 0) begin
                vectors++; if (ext_req !== 1'b1 || ext_addr !== exp_a || ext_we !== exp_we) begin errors++; $display("FAIL rnd_ext c=%0d req=%b a=%h we=%b exp 1/%h/%b", c, ext_req, ext_addr, ext_we, exp_a, exp_we); end
                if (d_done) begin
                    exp_d = d_we ? 32'h0 : mem[d_a[5:2]];
                    vectors++; if (dm_rdata !== exp_d) begin errors++; $display("FAIL rnd_dm_rdata c=%0d got %h exp %h", c, dm_rdata, exp_d); end
                    if (d_we) mem[d_a[5:2]] = d_wd;
                    d_act = 0; owner = 0;
                end else if (i_done) begin
                    vectors++; if (if_rdata !== mem[i_a[5:2]]) begin errors++; $display("FAIL rnd_if_rdata c=%0d got %h exp %h", c, if_rdata, mem[i_a[5:2]]); end
                    i_act = 0; owner = 0;
                end else begin
                    waitc++;
                end
            end else begin
                vectors++; if (ext_req !== 1'b0) begin errors++; $display("FAIL rnd_idle c=%0d req=%b exp 0", c, ext_req); end
                if (d_act && starve < 4) begin
                    owner = 2; exp_a = d_a; exp_we = d_we; starve = i_act ? starve + 1 : 0;
                end else if (i_act) begin
                    owner = 1; exp_a = i_a; exp_we = 0; starve = 0;
                end
                lat = $urandom_range(0, 3); waitc = 0;
            end
        end
        cyc(); clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_ld_and_fetch();
        test_store();
        test_starvation();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
